// File: rtl/display_pkg.sv
// Shared definitions for the display adaptor's ping-pong frame buffer.
package display_pkg;

    // Writer state: waiting for an empty buffer, or filling one.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } wr_state_e;

    // Default pixel byte width and bytes per buffer fill.
    localparam int DEFAULT_DATA_W      = 8;
    localparam int DEFAULT_FRAME_BYTES = 180;

    // Buffer-select encoding, shared with the display reader.
    localparam logic BUF0 = 1'b0;
    localparam logic BUF1 = 1'b1;

endpackage : display_pkg

// File: rtl/frame_addr_counter.sv
// Byte address counter for one buffer fill: counts 0..FRAME_BYTES-1,
// wraps to 0 after the terminal count, and can be cleared on an abort.
module frame_addr_counter #(
    parameter int FRAME_BYTES = 180,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] cnt,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap on the final byte.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST_ADDR) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == LAST_ADDR);

endmodule : frame_addr_counter

// File: rtl/display_frame_writer.sv
// Producer side of the ping-pong frame buffer: accepts pixel bytes over
// valid/ready and writes them into whichever buffer is next in strict
// alternation, once the reader has reported that buffer empty.
module display_frame_writer
    import display_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int FRAME_BYTES = DEFAULT_FRAME_BYTES,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CSDisplay,
    input  logic              Buf0Empty,
    input  logic              Buf1Empty,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              Buf0Full,
    output logic              Buf1Full
);

    wr_state_e         state_q,     state_d;
    logic              next_buf_q,  next_buf_d;
    logic              wr_en_q,     wr_en_d;
    logic              wr_sel_q,    wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,   wr_data_d;
    logic              buf0_full_q, buf0_full_d;
    logic              buf1_full_q, buf1_full_d;

    logic              cnt_clear;
    logic              cnt_inc;
    logic [ADDR_W-1:0] cnt;
    logic              cnt_last;
    logic              next_empty;

    frame_addr_counter #(
        .FRAME_BYTES (FRAME_BYTES),
        .ADDR_W      (ADDR_W)
    ) u_addr_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // Only the flag of the buffer due next matters; this enforces alternation.
    assign next_empty = (next_buf_q == BUF0) ? Buf0Empty : Buf1Empty;

    // Next-state and registered-output logic for the fill FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d     = state_q;
        next_buf_d  = next_buf_q;
        wr_en_d     = 1'b0;
        wr_sel_d    = wr_sel_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        buf0_full_d = 1'b0;
        buf1_full_d = 1'b0;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (CSDisplay && next_empty) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!CSDisplay) begin
                    // Abort: same buffer restarts from address 0 on the next fill.
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                end else if (pix_valid) begin
                    cnt_inc   = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_sel_d  = next_buf_q;
                    wr_addr_d = cnt;
                    wr_data_d = pix_data;
                    if (cnt_last) begin
                        state_d     = IDLE;
                        next_buf_d  = ~next_buf_q;
                        buf0_full_d = (next_buf_q == BUF0);
                        buf1_full_d = (next_buf_q == BUF1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer pointer and RAM-side output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_buf_q  <= BUF0;
            wr_en_q     <= 1'b0;
            wr_sel_q    <= BUF0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            buf0_full_q <= 1'b0;
            buf1_full_q <= 1'b0;
        end else begin
            next_buf_q  <= next_buf_d;
            wr_en_q     <= wr_en_d;
            wr_sel_q    <= wr_sel_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            buf0_full_q <= buf0_full_d;
            buf1_full_q <= buf1_full_d;
        end
    end

    assign pix_ready = (state_q == FILL);
    assign wr_en     = wr_en_q;
    assign wr_sel    = wr_sel_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign Buf0Full  = buf0_full_q;
    assign Buf1Full  = buf1_full_q;

endmodule : display_frame_writer

// File: doc/display_frame_writer.md
# display_frame_writer

Producer side of the display adaptor's ping-pong frame buffer. It accepts pixel bytes from an upstream source over a valid/ready handshake and writes them into buffer 0 or buffer 1, whichever the display reader has reported empty. Buffers alternate strictly. It sits between the pixel source and the two frame RAMs that `topdisplay` drains onto `Frameout`.

## Interface
Parameters:
- `DATA_W`, 8: pixel byte width.
- `FRAME_BYTES`, 180: bytes per buffer fill.
- `ADDR_W`, 8: buffer address width; must satisfy 2^ADDR_W >= FRAME_BYTES.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `CSDisplay`  in  1  display enable; fills start only while high.
- `Buf0Empty`  in  1  reader reports buffer 0 drained, level.
- `Buf1Empty`  in  1  reader reports buffer 1 drained, level.
- `pix_valid`  in  1  source byte valid.
- `pix_data`  in  DATA_W  source byte.
- `pix_ready`  out  1  writer can accept a byte.
- `wr_en`  out  1  RAM write strobe, registered.
- `wr_sel`  out  1  target buffer, 0 or 1, registered.
- `wr_addr`  out  ADDR_W  RAM address, registered.
- `wr_data`  out  DATA_W  RAM data, registered.
- `Buf0Full`  out  1  one-cycle pulse when buffer 0 is completely written.
- `Buf1Full`  out  1  one-cycle pulse when buffer 1 is completely written.

## Operation
- State machine states: `IDLE`, `FILL`. A `next_buf` pointer selects the buffer to fill next. A byte counter `cnt` runs from 0 to FRAME_BYTES-1.
- Reset sets: state `IDLE`, `next_buf`=0, `cnt`=0. All outputs read 0, including `pix_ready`.
- `IDLE` → `FILL`: when `CSDisplay`=1 and the empty flag of `next_buf` is 1. The empty flag of the other buffer is ignored, so strict alternation holds even when both flags are set.
- In `FILL`, `pix_ready`=1. This is a Moore output.
- A byte is accepted on any cycle with `pix_valid && pix_ready`. On acceptance the writer registers `wr_en`=1, `wr_sel`=`next_buf`, `wr_addr`=`cnt`, `wr_data`=`pix_data`, and increments `cnt`.
- Cycles with no acceptance: `wr_en`=0. `wr_addr` and `wr_data` hold their values.
- Last byte accepted (`cnt`=FRAME_BYTES-1):
  - `cnt` clears to 0.
  - `next_buf` toggles.
  - State returns to `IDLE`.
  - The matching `BufNFull` pulses together with the final `wr_en`.
- Empty flags are sampled only in `IDLE`. A flag that changes during `FILL` has no effect.
- `CSDisplay` falling during `FILL` aborts the fill:
  - Return to `IDLE` and clear `cnt`.
  - `next_buf` is unchanged and no Full pulse is issued.
  - A byte presented in that same cycle is not accepted, because `pix_ready` drops on the next edge.
  - A later fill restarts that buffer at address 0.
- `reset` mid-fill: every register clears immediately, with no Full pulse.

## Timing
- Entry latency: the condition is seen at edge N; state is `FILL` and `pix_ready`=1 after edge N.
- Write latency: a byte accepted at edge T appears on `wr_*` after edge T, one cycle later.
- Completion: the last byte accepted at edge T drives `wr_en`, `BufNFull`=1 and `pix_ready`=0 after edge T. The earliest next `pix_ready` comes one cycle later.
- Maximum throughput: FRAME_BYTES bytes per FRAME_BYTES+1 cycles.
- `Buf0Full` and `Buf1Full` are never high in the same cycle. Each is high for exactly one cycle per completed fill.

## Structure
- Shared package `display_pkg` holds:
  - the state enum (`IDLE`, `FILL`);
  - default `DATA_W` and `FRAME_BYTES`;
  - the buffer-select constants `BUF0`=0 and `BUF1`=1, shared with the reader.
- One optional sub-module, `frame_addr_counter`, with wrap at FRAME_BYTES-1, a clear input and a terminal-count output. The FSM and the output registers stay in the top module.

## Test plan
- Reset, then `CSDisplay`=1, `Buf0Empty`=1, `pix_valid` held high with data 0..179. Required: `wr_sel`=0 and `wr_addr`=0..179 with matching data; `Buf0Full` pulses once with address 179; then `pix_ready`=0.
- Both empty flags high for two full frames. Required: the first fill targets buffer 0 and the second targets buffer 1 (`Buf1Full` pulse); there is never a back-to-back fill of the same buffer.
- After buffer 0 fills, only `Buf0Empty`=1 and `Buf1Empty`=0. Required: the writer stays in `IDLE` with `pix_ready`=0 until `Buf1Empty` rises.
- `pix_valid` toggling every other cycle. Required: addresses remain contiguous, `wr_en` appears only on accepted cycles, and the fill completes after 360 cycles.
- Drop `CSDisplay` after byte 50. Required: no Full pulse, and `pix_ready`=0 on the next cycle. When `CSDisplay` is reasserted, the same buffer refills from `wr_addr`=0.
- Assert `reset` at byte 100. Required: all outputs 0 asynchronously; the next fill targets buffer 0 at address 0.
